// File: rtl/floppy_drive_mech.sv
// Behavioural model of one Amiga 3.5" floppy drive mechanism: decodes the CIA B
// disk-control bus and drives the /INDEX, /TRK0, /RDY, /CHNG and /WPRO status lines.
module floppy_drive_mech #(
    parameter int unsigned INDEX_PERIOD = 1418758,
    parameter int unsigned INDEX_WIDTH  = 142,
    parameter int unsigned SPINUP_TICKS = 354689,
    parameter int unsigned MAX_TRACK    = 79,
    parameter logic [31:0] DRIVE_ID     = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk7_en,
    input  logic       _sel,
    input  logic       _mtr,
    input  logic       _step,
    input  logic       dir,
    input  logic       _side,
    input  logic       disk_present,
    input  logic       wprot_in,
    output logic       _index,
    output logic       _trk0,
    output logic       _ready,
    output logic       _chng,
    output logic       _wprot,
    output logic [6:0] track,
    output logic       side,
    output logic       motor_on
);

    localparam int IDX_W  = $clog2(INDEX_PERIOD) + 1;
    localparam int SPIN_W = $clog2(SPINUP_TICKS) + 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INDEX_PERIOD - 1);
    localparam logic [IDX_W-1:0]  IDX_PULSE = IDX_W'(INDEX_WIDTH);
    localparam logic [SPIN_W-1:0] SPIN_DONE = SPIN_W'(SPINUP_TICKS);
    localparam logic [6:0]        TRACK_MAX = 7'(MAX_TRACK);

    logic              sel_q;
    logic              step_q;
    logic              disk_q;
    logic              chng;
    logic [31:0]       idreg;
    logic [SPIN_W-1:0] spin_cnt;
    logic [IDX_W-1:0]  idx_cnt;

    logic              sel_fall;
    logic              step_rise;
    logic              disk_fall;
    logic              step_ok;
    logic              running;
    logic              motor_n;
    logic [31:0]       idreg_n;
    logic [SPIN_W-1:0] spin_n;
    logic [6:0]        track_n;
    logic              chng_n;
    logic [IDX_W-1:0]  idx_n;
    logic              spun_up_n;

    assign side = ~_side;

    always_comb begin
        sel_fall  = sel_q & ~_sel;
        step_rise = ~step_q & _step;
        disk_fall = disk_q & ~disk_present;
        step_ok   = step_rise & ~_sel;
        running   = motor_on & (spin_cnt == SPIN_DONE) & disk_present;

        motor_n = motor_on;
        idreg_n = idreg;
        spin_n  = spin_cnt;
        if (sel_fall) begin
            motor_n = ~_mtr;
        end

        // A select edge that stops the motor restarts the ID sequence; further
        // selects with the motor left off clock the ID out one bit at a time.
        if (sel_fall && motor_on && _mtr) begin
            idreg_n = DRIVE_ID;
            spin_n  = '0;
        end else begin
            if (sel_fall && !motor_on && _mtr) begin
                idreg_n = {idreg[30:0], idreg[31]};
            end
            if (motor_on && (spin_cnt != SPIN_DONE)) begin
                spin_n = spin_cnt + 1'b1;
            end
        end
        spun_up_n = (spin_n == SPIN_DONE) & disk_present;

        track_n = track;
        if (step_ok) begin
            if (dir) begin
                if (track != 7'd0) begin
                    track_n = track - 7'd1;
                end
            end else if (track < TRACK_MAX) begin
                track_n = track + 7'd1;
            end
        end

        // Removal dominates a coincident step so a swap is never missed.
        chng_n = chng;
        if (disk_fall) begin
            chng_n = 1'b0;
        end else if (step_ok && disk_present) begin
            chng_n = 1'b1;
        end

        idx_n = idx_cnt;
        if (running) begin
            idx_n = (idx_cnt == IDX_LAST) ? '0 : idx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sel_q    <= 1'b1;
            step_q   <= 1'b1;
            disk_q   <= 1'b1;
            chng     <= 1'b0;
            idreg    <= DRIVE_ID;
            spin_cnt <= '0;
            idx_cnt  <= '0;
            track    <= 7'd0;
            motor_on <= 1'b0;
            _index   <= 1'b1;
            _trk0    <= 1'b1;
            _ready   <= 1'b1;
            _chng    <= 1'b1;
            _wprot   <= 1'b1;
        end else if (clk7_en) begin
            sel_q    <= _sel;
            step_q   <= _step;
            disk_q   <= disk_present;
            chng     <= chng_n;
            idreg    <= idreg_n;
            spin_cnt <= spin_n;
            idx_cnt  <= idx_n;
            track    <= track_n;
            motor_on <= motor_n;
            // Status lines float high whenever the drive is not selected.
            _index   <= _sel | ~(running & (idx_cnt < IDX_PULSE));
            _trk0    <= _sel | (track_n != 7'd0);
            _ready   <= _sel | (motor_n ? ~spun_up_n : ~idreg_n[31]);
            _chng    <= _sel | chng_n;
            _wprot   <= _sel | ~(disk_present & wprot_in);
        end
    end

endmodule
